// File: rtl/cmp_cond.sv
// cmp_cond: evaluates a 4-bit condition code against a set of comparator
// flags, queues {TAKEN,ERR} results in a small FIFO, and keeps saturating
// statistics of the results that the consumer pops.
//
// Handshakes
//   - Input side:  a beat is accepted when in_valid && in_ready.
//   - Output side: the head result is popped when out_valid && out_ready.
//
// Timing
//   - Results are evaluated on the accepting edge and registered.
//     There is no combinational path from the inputs to the outputs.
//   - in_ready depends only on the registered occupancy. A full FIFO
//     therefore refuses a beat even in a cycle where the head is being
//     popped.
//
// Parameters
//   - DEPTH is 2 or 4. Pointers wrap explicitly at DEPTH-1, so the wrap
//     does not rely on the pointer width.
//   - CNTW is the width of the statistics counters.

module cmp_cond #(
   parameter int DEPTH = 2,
   parameter int CNTW  = 8
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            in_valid,
   output logic            in_ready,
   input  logic            EQ,
   input  logic            SG,
   input  logic            UG,
   input  logic            MG,
   input  logic            XG,
   input  logic [3:0]      COND,

   output logic            out_valid,
   input  logic            out_ready,
   output logic            TAKEN,
   output logic            ERR,

   output logic [CNTW-1:0] TAKEN_CNT,
   output logic [CNTW-1:0] ERR_CNT
);

   // -----------------------------------------------------------------
   // Local types and sizes
   // -----------------------------------------------------------------
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;   // pointer width
   localparam int CW = $clog2(DEPTH + 1);                 // count width 0..DEPTH

   localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
   localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

   // One stored result.
   typedef struct packed {
      logic taken;
      logic err;
   } result_t;

   // Condition codes, named after the relation they test.
   typedef enum logic [3:0] {
      C_EQ     = 4'd0,
      C_NE     = 4'd1,
      C_SGT    = 4'd2,
      C_SLE    = 4'd3,
      C_SGE    = 4'd4,
      C_SLT    = 4'd5,
      C_UGT    = 4'd6,
      C_ULE    = 4'd7,
      C_UGE    = 4'd8,
      C_ULT    = 4'd9,
      C_MGT    = 4'd10,
      C_MLE    = 4'd11,
      C_XGT    = 4'd12,
      C_XLE    = 4'd13,
      C_ALWAYS = 4'd14,
      C_NEVER  = 4'd15
   } cond_e;

   // -----------------------------------------------------------------
   // Condition evaluation
   // -----------------------------------------------------------------

   // Raw condition decode, before any consistency override.
   function automatic logic decode_cond(
      input logic [3:0] cond,
      input logic eq,
      input logic sg,
      input logic ug,
      input logic mg,
      input logic xg
   );
      logic t;
      t = 1'b0;
      case (cond_e'(cond))
         C_EQ:     t = eq;
         C_NE:     t = ~eq;
         C_SGT:    t = sg;
         C_SLE:    t = ~sg;
         C_SGE:    t = sg | eq;
         C_SLT:    t = ~(sg | eq);
         C_UGT:    t = ug;
         C_ULE:    t = ~ug;
         C_UGE:    t = ug | eq;
         C_ULT:    t = ~(ug | eq);
         C_MGT:    t = mg;
         C_MLE:    t = ~mg;
         C_XGT:    t = xg;
         C_XLE:    t = ~xg;
         C_ALWAYS: t = 1'b1;
         C_NEVER:  t = 1'b0;
         default:  t = 1'b0;
      endcase
      return t;
   endfunction

   // Flag-set consistency and final result.
   //   - Equality cannot coexist with a signed, unsigned or
   //     signed-vs-unsigned "greater" flag; that combination raises ERR.
   //   - EQ together with XG is a legal mixed-sign case and is accepted.
   //   - An inconsistent set forces TAKEN low, except for the
   //     unconditional code, which stays taken.
   function automatic result_t evaluate(
      input logic [3:0] cond,
      input logic eq,
      input logic sg,
      input logic ug,
      input logic mg,
      input logic xg
   );
      result_t r;
      r.err   = eq & (sg | ug | mg);
      r.taken = decode_cond(cond, eq, sg, ug, mg, xg);
      if (r.err && (cond_e'(cond) != C_ALWAYS)) begin
         r.taken = 1'b0;
      end
      return r;
   endfunction

   // -----------------------------------------------------------------
   // FIFO state
   // -----------------------------------------------------------------
   result_t          mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [CW-1:0]    count;

   logic             push;
   logic             pop;
   result_t          head;
   result_t          new_result;

   // Pointer advance with explicit wrap at DEPTH-1.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Handshake decode and result evaluation for the current input beat.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      new_result = '0;

      in_ready   = (count != FULL_CNT);
      out_valid  = (count != '0);
      push       = in_valid & in_ready;
      pop        = out_valid & out_ready;
      new_result = evaluate(COND, EQ, SG, UG, MG, XG);
   end

   // Pointer and occupancy update; reset wins over any accept or pop.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= next_ptr(wptr);
         if (pop)  rptr <= next_ptr(rptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Result storage written on accepting edges.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is not reset; stale entries are never visible because the outputs are gated by occupancy.
      if (!rst && push) begin
         mem[wptr] <= new_result;
      end
   end

   // Head result presentation; forced to zero while the FIFO is empty.
   always_comb begin
      head  = mem[rptr];
      TAKEN = 1'b0;
      ERR   = 1'b0;
      if (out_valid) begin
         TAKEN = head.taken;
         ERR   = head.err;
      end
   end

   // Saturating statistics, advanced only by popped results.
   always_ff @(posedge clk) begin
      if (rst) begin
         TAKEN_CNT <= '0;
         ERR_CNT   <= '0;
      end else if (pop) begin
         if (head.taken && (TAKEN_CNT != CNT_MAX)) TAKEN_CNT <= TAKEN_CNT + 1'b1;
         if (head.err   && (ERR_CNT   != CNT_MAX)) ERR_CNT   <= ERR_CNT + 1'b1;
      end
   end

endmodule

// File: tb/tb_cmp_cond.sv
// tb_cmp_cond: table-driven check of condition decode and error flagging,
// followed by hand-written sequences for backpressure, simultaneous
// accept/pop, reset mid-stream and counter saturation.
`timescale 1ns/1ps

module tb_cmp_cond;

   localparam int DEPTH = 2;
   localparam int CNTW  = 8;
   localparam int CMAX  = (1 << CNTW) - 1;

   localparam logic [4:0] F_NONE = 5'b00000;
   localparam logic [4:0] F_EQ   = 5'b10000;
   localparam logic [4:0] F_SG   = 5'b01000;
   localparam logic [4:0] F_UG   = 5'b00100;
   localparam logic [4:0] F_MG   = 5'b00010;
   localparam logic [4:0] F_XG   = 5'b00001;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic            EQ, SG, UG, MG, XG;
   logic [3:0]      COND;
   logic            out_valid;
   logic            out_ready;
   logic            TAKEN;
   logic            ERR;
   logic [CNTW-1:0] TAKEN_CNT;
   logic [CNTW-1:0] ERR_CNT;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_tc  = 0;
   int exp_ec  = 0;

   typedef struct {
      string      name;
      logic [4:0] flags;   // {EQ,SG,UG,MG,XG}
      logic [3:0] cond;
      logic       taken;
      logic       err;
   } vec_t;

   vec_t vecs[$];

   cmp_cond #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .EQ        (EQ),
      .SG        (SG),
      .UG        (UG),
      .MG        (MG),
      .XG        (XG),
      .COND      (COND),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .TAKEN     (TAKEN),
      .ERR       (ERR),
      .TAKEN_CNT (TAKEN_CNT),
      .ERR_CNT   (ERR_CNT)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string n, input logic [4:0] f, input logic [3:0] c,
                               input logic t, input logic e);
      vec_t v;
      v.name = n; v.flags = f; v.cond = c; v.taken = t; v.err = e;
      return v;
   endfunction

   function automatic int sat_add(input int a, input int n);
      return (a + n > CMAX) ? CMAX : a + n;
   endfunction

   task automatic drive(input logic [4:0] f, input logic [3:0] c, input logic v);
      {EQ, SG, UG, MG, XG} = f;
      COND     = c;
      in_valid = v;
   endtask

   // Not accepting: flags and code take random values that must be ignored.
   task automatic idle();
      drive(5'($urandom), 4'($urandom), 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_taken_cnt"}, int'(TAKEN_CNT), exp_tc);
      check({tag, "_err_cnt"},   int'(ERR_CNT),   exp_ec);
   endtask

   initial begin
      // Decode and consistency vectors, expected values computed by hand.
      vecs.push_back(mk("single_eq",   F_EQ, 4'd0, 1'b1, 1'b0));
      begin
         logic [15:0] ug_exp;
         ug_exp = 16'b0110_1001_0110_1010;   // bit i = TAKEN for COND i with UG=1
         for (int i = 0; i < 16; i++)
            vecs.push_back(mk($sformatf("ug_sweep_%0d", i), F_UG, 4'(i), ug_exp[i], 1'b0));
      end
      vecs.push_back(mk("eq_ug_c6",    F_EQ | F_UG, 4'd6,  1'b0, 1'b1));
      vecs.push_back(mk("eq_xg_c12",   F_EQ | F_XG, 4'd12, 1'b1, 1'b0));
      vecs.push_back(mk("eq_sg_c4",    F_EQ | F_SG, 4'd4,  1'b0, 1'b1));
      vecs.push_back(mk("eq_mg_c14",   F_EQ | F_MG, 4'd14, 1'b1, 1'b1));
      vecs.push_back(mk("eq_sg_c11",   F_EQ | F_SG, 4'd11, 1'b0, 1'b1));
      vecs.push_back(mk("sg_c5",       F_SG,        4'd5,  1'b0, 1'b0));
      vecs.push_back(mk("mg_c10",      F_MG,        4'd10, 1'b1, 1'b0));
      vecs.push_back(mk("xg_c13",      F_XG,        4'd13, 1'b0, 1'b0));
      vecs.push_back(mk("none_c9",     F_NONE,      4'd9,  1'b1, 1'b0));
      vecs.push_back(mk("sg_ug_c8",    F_SG | F_UG, 4'd8,  1'b1, 1'b0));

      // Reset state.
      rst = 1'b1; out_ready = 1'b0; idle();
      tick(); tick();
      rst = 1'b0;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready",  int'(in_ready),  1);
      check("rst_taken",     int'(TAKEN),     0);
      check("rst_err",       int'(ERR),       0);
      check_counters("rst");

      // Table-driven single beats: accept, see result next cycle, pop.
      foreach (vecs[i]) begin
         drive(vecs[i].flags, vecs[i].cond, 1'b1);
         out_ready = 1'b1;
         #1;
         check({vecs[i].name, "_no_comb_path"}, int'(out_valid), 0);
         check({vecs[i].name, "_in_ready"},     int'(in_ready),  1);
         tick();
         idle();
         check({vecs[i].name, "_out_valid"}, int'(out_valid), 1);
         check({vecs[i].name, "_taken"},     int'(TAKEN),     int'(vecs[i].taken));
         check({vecs[i].name, "_err"},       int'(ERR),       int'(vecs[i].err));
         tick();
         if (vecs[i].taken) exp_tc = sat_add(exp_tc, 1);
         if (vecs[i].err)   exp_ec = sat_add(exp_ec, 1);
         check({vecs[i].name, "_drained"}, int'(out_valid), 0);
         check_counters(vecs[i].name);
      end

      // Backpressure: fill both entries with out_ready low.
      out_ready = 1'b0;
      drive(F_SG, 4'd2, 1'b1); tick();
      drive(F_SG, 4'd3, 1'b1); tick();
      drive(F_EQ, 4'd0, 1'b1);                 // offered while full: must be refused
      check("bp_in_ready_full", int'(in_ready),  0);
      check("bp_out_valid",     int'(out_valid), 1);
      check("bp_head_taken",    int'(TAKEN),     1);
      tick();
      check("bp_head_stable",   int'(TAKEN),     1);
      check("bp_still_full",    int'(in_ready),  0);
      check_counters("bp_no_pop");
      idle();
      out_ready = 1'b1;
      tick();
      exp_tc = sat_add(exp_tc, 1);
      check("bp_second_valid",  int'(out_valid), 1);
      check("bp_second_taken",  int'(TAKEN),     0);
      check("bp_ready_after",   int'(in_ready),  1);
      tick();
      check("bp_empty",         int'(out_valid), 0);
      check_counters("bp");

      // Simultaneous accept and pop at occupancy 1.
      out_ready = 1'b0;
      drive(F_UG, 4'd6, 1'b1); tick();
      out_ready = 1'b1;
      drive(F_UG, 4'd7, 1'b1); tick();
      exp_tc = sat_add(exp_tc, 1);
      idle();
      check("sim_out_valid", int'(out_valid), 1);
      check("sim_in_ready",  int'(in_ready),  1);
      check("sim_taken",     int'(TAKEN),     0);
      tick();
      check("sim_empty",     int'(out_valid), 0);
      check_counters("sim");

      // Reset mid-stream with a concurrent accept and pop on the reset edge.
      out_ready = 1'b0;
      drive(F_NONE, 4'd14, 1'b1); tick();
      drive(F_NONE, 4'd14, 1'b1); tick();
      check("mid_full", int'(in_ready), 0);
      rst = 1'b1; out_ready = 1'b1;
      drive(F_NONE, 4'd14, 1'b1);
      tick();
      rst = 1'b0; out_ready = 1'b0; idle();
      exp_tc = 0; exp_ec = 0;
      check("mid_out_valid", int'(out_valid), 0);
      check("mid_in_ready",  int'(in_ready),  1);
      check("mid_taken",     int'(TAKEN),     0);
      check("mid_err",       int'(ERR),       0);
      check_counters("mid_rst");
      drive(F_EQ | F_UG, 4'd6, 1'b1); tick();
      idle();
      check("mid_next_valid", int'(out_valid), 1);
      check("mid_next_taken", int'(TAKEN),     0);
      check("mid_next_err",   int'(ERR),       1);
      out_ready = 1'b1;
      tick();
      exp_ec = sat_add(exp_ec, 1);
      check("mid_next_drained", int'(out_valid), 0);
      check_counters("mid_next");

      // Saturation: 300 taken results streamed through.
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         drive(F_NONE, 4'd14, 1'b1);
         tick();
      end
      idle();
      begin
         int budget;
         budget = 0;
         while (out_valid && budget < 8) begin
            tick();
            budget++;
         end
         check("sat_drain_in_time", int'(out_valid), 0);
      end
      exp_tc = sat_add(exp_tc, 300);
      check_counters("sat");
      drive(F_NONE, 4'd14, 1'b1); tick();
      idle(); tick();
      check_counters("sat_hold");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cmp_cond.md
CMP_COND -- requirements
Module: cmp_cond

Interface
REQ-001 Parameter DEPTH, default 2: result FIFO depth; legal values 2 or 4.
REQ-002 Parameter CNTW, default 8: width of the statistics counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  a flag set and condition are presented.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 EQ, SG, UG, MG, XG  input  1 each  comparator flags: A==B, signed>signed, unsigned>unsigned, signed A>unsigned B, unsigned A>signed B.
REQ-008 COND  input  4  condition code to evaluate against the flags.
REQ-009 out_valid  output  1  head result valid.
REQ-010 out_ready  input  1  consumer accepts head result.
REQ-011 TAKEN  output  1  head result: condition true.
REQ-012 ERR  output  1  head result: flag set was inconsistent.
REQ-013 TAKEN_CNT  output  CNTW  popped results with TAKEN=1, saturating.
REQ-014 ERR_CNT  output  CNTW  popped results with ERR=1, saturating.

Function
REQ-015 Accept occurs when in_valid and in_ready are high on the same edge; pop occurs when out_valid and out_ready are high on the same edge.
REQ-016 COND decode (TAKEN): 0 EQ; 1 !EQ; 2 SG; 3 !SG; 4 SG|EQ; 5 !(SG|EQ); 6 UG; 7 !UG; 8 UG|EQ; 9 !(UG|EQ); 10 MG; 11 !MG; 12 XG; 13 !XG; 14 1; 15 0.
REQ-017 ERR is computed as EQ&(SG|UG|MG); EQ&XG is legal and does not raise ERR.
REQ-018 When ERR=1 the stored TAKEN is forced to 0, except for COND=14, which stays 1.
REQ-019 Evaluation occurs on the accepting edge; {TAKEN,ERR} is written into a DEPTH-entry FIFO in accept order.
REQ-020 Latency: a beat accepted into an empty FIFO at edge N gives out_valid=1 after edge N, with no combinational in-to-out path.
REQ-021 in_ready is the negation of FIFO full, and depends only on registered state, not on out_ready.
REQ-022 When full, a pop frees one entry; in_ready rises only after the popping edge, so push-on-full never occurs.
REQ-023 Simultaneous accept and pop when neither full nor empty: occupancy is unchanged and order is preserved.
REQ-024 When empty: out_valid=0, and TAKEN and ERR are 0.
REQ-025 When out_valid=1 and out_ready=0, TAKEN and ERR stay stable until popped.
REQ-026 Read and write pointers wrap modulo DEPTH; occupancy is tracked with a count register of 0..DEPTH.
REQ-027 TAKEN_CNT increments by 1 on each pop with TAKEN=1, and holds at 2^CNTW-1.
REQ-028 ERR_CNT increments by 1 on each pop with ERR=1, and holds at 2^CNTW-1.
REQ-029 The counters change only on pops; accepts alone do not change them.
REQ-030 Flags and COND are sampled only on accepting edges; values on other cycles are ignored.

Reset
REQ-031 On an edge with rst=1, the block empties the FIFO and clears the pointers, TAKEN_CNT and ERR_CNT.
REQ-032 After that reset edge, out_valid=0, TAKEN=0, ERR=0, in_ready=1 and both counters read 0.
REQ-033 Reset takes priority over a concurrent accept or pop on the same edge; both are discarded and the counters do not increment.
REQ-034 Reset mid-operation discards all buffered results without producing any output beat.

Verification
REQ-035 Single beat: EQ=1, others 0, COND=0, out_ready=1 -> next cycle out_valid=1, TAKEN=1, ERR=0; after the pop, TAKEN_CNT=1.
REQ-036 Decode sweep: UG=1, others 0, COND 0..15 -> TAKEN = 0,1,0,1,0,1,1,0,1,0,0,1,0,1,1,0.
REQ-037 Backpressure, DEPTH=2, out_ready=0: accept SG=1 with COND=2, then COND=3 -> in_ready=0 after the second accept, head TAKEN=1 stable.
REQ-037 (continued) Raising out_ready then yields TAKEN=1 then 0, in order.
REQ-038 Inconsistent flags: EQ=1, UG=1, COND=6 -> TAKEN=0, ERR=1, ERR_CNT=1; EQ=1, XG=1, COND=12 -> TAKEN=1, ERR=0.
REQ-039 Saturation, CNTW=8: 300 pops of COND=14 -> TAKEN_CNT=255, holding.
REQ-040 Reset mid-stream: 2 entries buffered, rst=1 for one cycle -> out_valid=0, in_ready=1, counters 0, and the next accept is the next output.
